// File: rtl/blowfish_decipher_if.sv
// rtl/blowfish_decipher_if.sv - request, result and key-schedule read ports of the Blowfish decipher
interface blowfish_decipher_if;
    logic        start;
    logic [31:0] xl_in;
    logic [31:0] xr_in;
    logic [9:0]  S_addr;
    logic [31:0] S_data;
    logic [4:0]  P_addr;
    logic [31:0] P_data;
    logic [31:0] xl_out;
    logic [31:0] xr_out;
    logic        busy;
    logic        done;

    modport slave (
        input  start, xl_in, xr_in, S_data, P_data,
        output S_addr, P_addr, xl_out, xr_out, busy, done
    );

    modport master (
        output start, xl_in, xr_in, S_data, P_data,
        input  S_addr, P_addr, xl_out, xr_out, busy, done
    );
endinterface

// File: rtl/blowfish_decipher.sv
// rtl/blowfish_decipher.sv - multi-cycle Blowfish block decipher, one S-box/P-array read per cycle
// Each round is four S-box reads building F(x) in f_acc, then one P read that folds it into a half.
module blowfish_decipher #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic                clk,
    input  logic                reset_l,
    blowfish_decipher_if.slave  bus
);

    localparam logic [4:0] ROUND_FIRST = 5'(NUM_ROUNDS);
    localparam logic [4:0] P_LAST      = 5'(NUM_ROUNDS + 1);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        F0,
        F1,
        F2,
        F3,
        PX,
        FIN,
        DONE
    } state_t;

    state_t      state_q,  state_d;
    logic [31:0] xl_q,     xl_d;
    logic [31:0] xr_q,     xr_d;
    logic [31:0] f_acc_q,  f_acc_d;
    logic [31:0] xl_out_q, xl_out_d;
    logic [31:0] xr_out_q, xr_out_d;
    logic [4:0]  round_q,  round_d;

    logic [9:0]  s_addr;
    logic [4:0]  p_addr;
    logic        busy;
    logic        done;
    logic [31:0] src;

    // Even rounds mix F(Xl) into Xr, odd rounds mix F(Xr) into Xl.
    assign src = round_q[0] ? xr_q : xl_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= IDLE;
            xl_q     <= '0;
            xr_q     <= '0;
            f_acc_q  <= '0;
            xl_out_q <= '0;
            xr_out_q <= '0;
            round_q  <= ROUND_FIRST;
        end else begin
            state_q  <= state_d;
            xl_q     <= xl_d;
            xr_q     <= xr_d;
            f_acc_q  <= f_acc_d;
            xl_out_q <= xl_out_d;
            xr_out_q <= xr_out_d;
            round_q  <= round_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        xl_d     = xl_q;
        xr_d     = xr_q;
        f_acc_d  = f_acc_q;
        xl_out_d = xl_out_q;
        xr_out_d = xr_out_q;
        round_d  = round_q;
        s_addr   = '0;
        p_addr   = '0;
        busy     = (state_q != IDLE);
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    xl_d    = bus.xl_in;
                    xr_d    = bus.xr_in;
                    state_d = INIT;
                end
            end
            INIT: begin
                p_addr  = P_LAST;
                xl_d    = xl_q ^ bus.P_data;
                round_d = ROUND_FIRST;
                state_d = F0;
            end
            F0: begin
                s_addr  = {2'd0, src[31:24]};
                f_acc_d = bus.S_data;
                state_d = F1;
            end
            F1: begin
                s_addr  = {2'd1, src[23:16]};
                f_acc_d = f_acc_q + bus.S_data;
                state_d = F2;
            end
            F2: begin
                s_addr  = {2'd2, src[15:8]};
                f_acc_d = f_acc_q ^ bus.S_data;
                state_d = F3;
            end
            F3: begin
                s_addr  = {2'd3, src[7:0]};
                f_acc_d = f_acc_q + bus.S_data;
                state_d = PX;
            end
            PX: begin
                p_addr = round_q;
                if (round_q[0]) begin
                    xl_d = xl_q ^ f_acc_q ^ bus.P_data;
                end else begin
                    xr_d = xr_q ^ f_acc_q ^ bus.P_data;
                end
                if (round_q == 5'd1) begin
                    state_d = FIN;
                end else begin
                    round_d = round_q - 5'd1;
                    state_d = F0;
                end
            end
            FIN: begin
                p_addr   = 5'd0;
                xl_out_d = xr_q ^ bus.P_data;
                xr_out_d = xl_q;
                state_d  = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.S_addr = s_addr;
    assign bus.P_addr = p_addr;
    assign bus.xl_out = xl_out_q;
    assign bus.xr_out = xr_out_q;
    assign bus.busy   = busy;
    assign bus.done   = done;

endmodule

// File: tb/tb_blowfish_decipher.sv
// tb/tb_blowfish_decipher.sv - scoreboard bench for blowfish_decipher with directed and round-trip blocks
module tb_blowfish_decipher;
    localparam int  NR = 16;
    localparam time T  = 10;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #(T / 2) clk = ~clk;

    blowfish_decipher_if bus ();

    blowfish_decipher #(.NUM_ROUNDS(NR)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    logic [31:0] p_mem [0:31];
    logic [31:0] s_mem [0:1023];

    assign bus.S_data = s_mem[bus.S_addr];
    assign bus.P_data = p_mem[bus.P_addr];

    typedef struct {
        logic [31:0] xl;
        logic [31:0] xr;
        time         t_done;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   dones  = 0;
    int   issued = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * 32'd1664525 + 32'd1013904223;
    endfunction

    function automatic logic [31:0] f_fn(input logic [31:0] x);
        logic [9:0] a0, a1, a2, a3;
        a0 = {2'd0, x[31:24]};
        a1 = {2'd1, x[23:16]};
        a2 = {2'd2, x[15:8]};
        a3 = {2'd3, x[7:0]};
        return ((s_mem[a0] + s_mem[a1]) ^ s_mem[a2]) + s_mem[a3];
    endfunction

    // Forward Blowfish (standard encipher with swaps), used to build ciphertexts.
    function automatic logic [63:0] encipher(input logic [63:0] blk);
        logic [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < NR; i++) begin
            l = l ^ p_mem[i];
            r = r ^ f_fn(l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ p_mem[NR];
        l = l ^ p_mem[NR + 1];
        return {l, r};
    endfunction

    task automatic load_const(input bit p_index);
        for (int i = 0; i < 32; i++) p_mem[i] = (p_index && i < NR + 2) ? 32'(i) : 32'h0;
        for (int i = 0; i < 1024; i++) s_mem[i] = 32'h0;
    endtask

    task automatic load_hash(input logic [31:0] seed);
        logic [31:0] x;
        x = seed;
        for (int i = 0; i < 32; i++) begin
            x = lcg(x);
            p_mem[i] = (i < NR + 2) ? x : 32'h0;
        end
        for (int i = 0; i < 1024; i++) begin
            x = lcg(x);
            s_mem[i] = x ^ {x[15:0], x[31:16]};
        end
    endtask

    // Issues one block, walks the 83 cycles after the start edge checking the
    // address/handshake sequence, and returns #1 after the edge that enters IDLE.
    task automatic run_op(input logic [31:0] xl, input logic [31:0] xr,
                          input logic [63:0] exp_lr, input bit collide);
        bit          seq_ok;
        time         te;
        int          j, ph, rnd;
        logic [4:0]  exp_p;
        seq_ok = 1'b1;
        bus.xl_in = xl;
        bus.xr_in = xr;
        bus.start = 1'b1;
        @(posedge clk);
        te = $time;
        sb.push_back('{exp_lr[63:32], exp_lr[31:0], te + 82 * T + T / 2});
        issued++;
        for (int n = 0; n <= 82; n++) begin
            @(negedge clk);
            ph = 5;
            exp_p = 5'd0;
            if (n == 0) begin
                exp_p = 5'(NR + 1);
            end else if (n <= 80) begin
                j   = n - 1;
                ph  = j % 5;
                rnd = NR - j / 5;
                if (ph == 4) exp_p = 5'(rnd);
            end
            if (bus.busy !== 1'b1) seq_ok = 1'b0;
            if (bus.done !== (n == 82)) seq_ok = 1'b0;
            if (bus.P_addr !== exp_p) seq_ok = 1'b0;
            if (ph < 4 && bus.S_addr[9:8] !== 2'(ph)) seq_ok = 1'b0;
            if (ph >= 4 && bus.S_addr !== 10'd0) seq_ok = 1'b0;
            bus.start = collide && (n == 9 || n == 81 || n == 82);
            bus.xl_in = $urandom;
            bus.xr_in = $urandom;
        end
        check("addr_busy_done_sequence", 64'(seq_ok), 64'd1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (collide) check("start_while_busy_ignored", 64'(bus.busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset_l && bus.done === 1'b1) begin
            exp_t e;
            dones++;
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("xl_out", 64'(bus.xl_out), 64'(e.xl));
                check("xr_out", 64'(bus.xr_out), 64'(e.xr));
                check("done_latency", 64'($time), 64'(e.t_done));
            end
        end
    end

    initial begin
        #(200000 * T);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] pl, ct, x;
        bus.start = 1'b0;
        bus.xl_in = 32'h0;
        bus.xr_in = 32'h0;
        load_const(1'b0);
        repeat (3) @(negedge clk);
        check("reset_xl_out", 64'(bus.xl_out), 64'd0);
        check("reset_xr_out", 64'(bus.xr_out), 64'd0);
        check("reset_busy",   64'(bus.busy),   64'd0);
        check("reset_done",   64'(bus.done),   64'd0);
        check("reset_s_addr", 64'(bus.S_addr), 64'd0);
        check("reset_p_addr", 64'(bus.P_addr), 64'd0);
        reset_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-zero schedule: F is zero, halves just swap.
        run_op(32'h01234567, 32'h89ABCDEF, {32'h89ABCDEF, 32'h01234567}, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // P[i] = i, S = 0: odd/even P chains cancel leaving 0x10 / 0x11.
        load_const(1'b1);
        run_op(32'h0, 32'h0, {32'h00000010, 32'h00000011}, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Round trips through the forward cipher on a pseudo-random schedule.
        load_hash(32'hB10F15D5);
        x = 64'h0123456789ABCDEF;
        for (int k = 0; k < 12; k++) begin
            case (k)
                0: pl = 64'h0;
                1: pl = 64'hFFFFFFFF_FFFFFFFF;
                2: pl = 64'h80000000_00000001;
                default: begin
                    x[63:32] = lcg(x[31:0]);
                    x[31:0]  = lcg(x[63:32]);
                    pl = x;
                end
            endcase
            ct = encipher(pl);
            run_op(ct[63:32], ct[31:0], pl, 1'b0);
            @(posedge clk);
            #1;
        end

        // Starts during busy/FIN/DONE ignored, then a start in the first IDLE cycle.
        pl = 64'hDEADBEEF_CAFEF00D;
        ct = encipher(pl);
        run_op(ct[63:32], ct[31:0], pl, 1'b1);
        pl = 64'h13579BDF_2468ACE0;
        ct = encipher(pl);
        run_op(ct[63:32], ct[31:0], pl, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-operation: abort, clear outputs, no done.
        pl = 64'h0F0F0F0F_F0F0F0F0;
        ct = encipher(pl);
        bus.xl_in = ct[63:32];
        bus.xr_in = ct[31:0];
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (39) @(negedge clk);
        reset_l = 1'b0;
        #1;
        check("abort_busy",   64'(bus.busy),   64'd0);
        check("abort_done",   64'(bus.done),   64'd0);
        check("abort_xl_out", 64'(bus.xl_out), 64'd0);
        check("abort_xr_out", 64'(bus.xr_out), 64'd0);
        check("abort_p_addr", 64'(bus.P_addr), 64'd0);
        @(negedge clk);
        reset_l = 1'b1;
        repeat (90) @(negedge clk);
        check("abort_stays_idle", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        run_op(ct[63:32], ct[31:0], pl, 1'b0);

        repeat (5) @(negedge clk);
        check("done_count", 64'(dones), 64'(issued));
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/blowfish_decipher.md
Name: blowfish_decipher

Overview:
- Inverse of the Blowfish encipher datapath. Takes one 64-bit ciphertext block as two 32-bit halves and returns the plaintext halves.
- Runs the 16 Feistel rounds with the P-array in reverse order, P[17] down to P[0].
- Sequences its own F-function reads through the shared S-box and P-box read ports, one table read per cycle.
- Sits beside the encipher block in the bcrypt core and shares the same key-schedule memories.

Parameters:
NUM_ROUNDS, 16, Feistel round count; must be even; P-array depth is NUM_ROUNDS+2.

Ports:
clk  input  1  rising-edge clock
reset_l  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
xl_in  input  32  ciphertext left half
xr_in  input  32  ciphertext right half
S_addr  output  10  S-box read address = {box[1:0], byte[7:0]}
S_data  input  32  S-box read data; combinational, valid in the same cycle as S_addr
P_addr  output  5  P-array read address
P_data  input  32  P-array read data; combinational, valid in the same cycle as P_addr
xl_out  output  32  plaintext left half
xr_out  output  32  plaintext right half
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, reset_l low):
  - state = IDLE.
  - Xl, Xr, f_acc, xl_out, xr_out = 0.
  - round counter = NUM_ROUNDS.
  - done = 0, busy = 0; S_addr and P_addr = 0.
  - Reset mid-operation aborts the block immediately. There is no partial result and no done pulse.
- Algorithm, with F(x) = ((S0[x31:24] + S1[x23:16]) ^ S2[x15:8]) + S3[x7:0]:
  - Step 1: Xl ^= P[17].
  - Step 2: for i = 16 down to 1:
    - i even: Xr ^= F(Xl) ^ P[i].
    - i odd: Xl ^= F(Xr) ^ P[i].
  - Step 3: xl_out = Xr ^ P[0]; xr_out = Xl.
- All additions are mod 2^32 (carry out discarded).
- States, one table read per state; S_addr and P_addr are 0 in any state that does not drive them:
  - IDLE: if start, latch Xl <= xl_in and Xr <= xr_in, then go to INIT. Otherwise stay.
  - INIT: P_addr = NUM_ROUNDS+1. Xl <= Xl ^ P_data. round <= NUM_ROUNDS. Go to F0.
  - F0..F3: src = Xl if round is even, else Xr.
    - F0: S_addr = {2'd0, src[31:24]}; f_acc <= S_data.
    - F1: S_addr = {2'd1, src[23:16]}; f_acc <= f_acc + S_data.
    - F2: S_addr = {2'd2, src[15:8]}; f_acc <= f_acc ^ S_data.
    - F3: S_addr = {2'd3, src[7:0]}; f_acc <= f_acc + S_data.
  - PX: P_addr = round.
    - round even: Xr <= Xr ^ f_acc ^ P_data. Round odd: Xl <= Xl ^ f_acc ^ P_data.
    - If round == 1, go to FIN. Otherwise round <= round - 1 and go to F0.
  - FIN: P_addr = 0. xl_out <= Xr ^ P_data; xr_out <= Xl. Go to DONE.
  - DONE: done = 1 for exactly one cycle. Go to IDLE.
- Latency:
  - Start is sampled on clock edge E.
  - done is high during the cycle following edge E+82: 1 INIT + 5 per round × 16 + 1 FIN + 1 cycle into DONE.
- Output hold: xl_out and xr_out change only in FIN. They hold their value until the next operation's FIN, or until reset.
- start while busy is ignored; there is no queueing.
- start asserted during the DONE cycle is ignored. A start in the first IDLE cycle after DONE is accepted.
- Input capture: xl_in and xr_in are captured only at the start edge. Later changes on them have no effect.
- Memory contents must stay stable for the whole operation. The block does not check this.

Test Plan:
- All P and S entries = 0; xl_in=0x01234567, xr_in=0x89ABCDEF; pulse start -> done 83 cycles after the start edge; xl_out=0x89ABCDEF, xr_out=0x01234567; busy high throughout.
- P[i]=i, all S=0; xl_in=xr_in=0 -> xl_out=0x00000010, xr_out=0x00000011.
- Zero-key Blowfish schedule loaded from the reference model; xl_in=0x4EF99745, xr_in=0x6198DD78 -> xl_out=0x00000000, xr_out=0x00000000.
- Random schedule and 1000 random blocks fed through encipher then decipher -> original block recovered every time. Also check the S_addr box field sequence 0,1,2,3 in every round and the P_addr sequence 17,16,...,1,0.
- Second start pulsed at cycles 10 and 82 after the first start -> both ignored; exactly one done; results unchanged. A start in the IDLE cycle after DONE is accepted.
- reset_l pulsed low at cycle 40 of an operation -> state IDLE immediately; outputs 0; no done pulse. A new operation then completes with the correct result.
